// File: rtl/command_wbuf.sv
// command_wbuf: host-to-device write-data buffer streaming stored dwords to the transport layer
module command_wbuf #(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [31:0]           al_data_in,
    input  logic                  al_data_val_in,
    output logic                  al_full_out,
    output logic [DEPTH_LOG2:0]   al_level_out,
    input  logic                  start_in,
    input  logic [DEPTH_LOG2:0]   xfer_len_in,
    input  logic                  abort_in,
    input  logic                  err_clr_in,
    output logic                  busy_out,
    output logic                  done_out,
    output logic [1:0]            err_out,
    output logic [31:0]           tl_data_out,
    output logic                  tl_data_val_out,
    output logic                  tl_data_last_out,
    input  logic                  tl_data_strobe_in
);
    localparam int D = DEPTH_LOG2;
    localparam int W = DEPTH_LOG2 + 1;
    localparam logic [D:0] FULL = {1'b1, {D{1'b0}}};

    typedef enum logic [1:0] {IDLE, FETCH, SEND} state_t;

    state_t         state_q, state_d;
    logic [31:0]    mem [2**DEPTH_LOG2];
    logic [D-1:0]   wr_q, wr_d, rd_q, rd_d, raddr;
    logic [D:0]     level_q, level_d, rem_q, rem_d;
    logic [31:0]    data_q;
    logic           val_q, val_d, done_q, done_d;
    logic [1:0]     err_q, err_d;
    logic           wr_en, accept, start_ok, start_bad, re;

    assign al_full_out      = level_q == FULL;
    assign al_level_out     = level_q;
    assign busy_out         = state_q != IDLE;
    assign done_out         = done_q;
    assign err_out          = err_q;
    assign tl_data_out      = data_q;
    assign tl_data_val_out  = val_q;
    assign tl_data_last_out = val_q && rem_q == W'(1);

    // Next-state logic; the output register doubles as the RAM read register, so it is
    // reloaded with the following dword exactly when the current one is accepted.
    always_comb begin
        wr_en     = al_data_val_in && !al_full_out && !abort_in;
        accept    = val_q && tl_data_strobe_in;
        start_ok  = state_q == IDLE && start_in && xfer_len_in != '0 && xfer_len_in <= level_q;
        start_bad = state_q == IDLE && start_in && !start_ok && !abort_in;
        state_d   = state_q;
        wr_d      = wr_q + D'(wr_en);
        rd_d      = rd_q + D'(accept);
        level_d   = level_q + W'(wr_en) - W'(accept);
        rem_d     = accept ? rem_q - W'(1) : rem_q;
        val_d     = val_q;
        done_d    = 1'b0;
        re        = 1'b0;
        raddr     = rd_q;
        case (state_q)
            IDLE: begin
                state_d = start_ok ? FETCH : IDLE;
                rem_d   = start_ok ? xfer_len_in : rem_q;
            end
            FETCH: begin
                state_d = SEND;
                val_d   = 1'b1;
                re      = 1'b1;
            end
            SEND: begin
                if (accept) begin
                    state_d = rem_q == W'(1) ? IDLE : SEND;
                    val_d   = rem_q != W'(1);
                    done_d  = rem_q == W'(1);
                    re      = rem_q != W'(1);
                    raddr   = rd_q + D'(1);
                end
            end
            default: state_d = IDLE;
        endcase
        err_d = (err_clr_in ? 2'b00 : err_q) | {start_bad, al_data_val_in && al_full_out && !abort_in};
        if (abort_in) begin
            state_d = IDLE;
            wr_d    = '0;
            rd_d    = '0;
            level_d = '0;
            rem_d   = '0;
            val_d   = 1'b0;
            done_d  = 1'b0;
            re      = 1'b0;
        end
    end

    // Buffer storage write port.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_q] <= al_data_in;
    end

    // Control, pointer and output registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            wr_q    <= '0;
            rd_q    <= '0;
            level_q <= '0;
            rem_q   <= '0;
            data_q  <= '0;
            val_q   <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 2'b00;
        end else begin
            state_q <= state_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            level_q <= level_d;
            rem_q   <= rem_d;
            val_q   <= val_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (re) data_q <= mem[raddr];
        end
    end
endmodule

// File: tb/tb_command_wbuf.sv
// tb_command_wbuf: vector-table and sequence checks for command_wbuf
module tb_command_wbuf;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] al_data_in;
    logic        al_data_val_in;
    logic        al_full_out;
    logic [10:0] al_level_out;
    logic        start_in;
    logic [10:0] xfer_len_in;
    logic        abort_in;
    logic        err_clr_in;
    logic        busy_out;
    logic        done_out;
    logic [1:0]  err_out;
    logic [31:0] tl_data_out;
    logic        tl_data_val_out;
    logic        tl_data_last_out;
    logic        tl_data_strobe_in;

    int passed = 0;
    int total  = 0;

    typedef struct {
        logic        wr;
        logic [31:0] d;
        logic        st;
        logic [10:0] len;
        logic        sb, ab, clr;
        logic [10:0] lvl;
        logic        val, last, busy, done;
        logic [1:0]  err;
        logic [31:0] q;
    } vec_t;

    vec_t tv[$];

    command_wbuf dut (
        .clk(clk), .rst(rst),
        .al_data_in(al_data_in), .al_data_val_in(al_data_val_in),
        .al_full_out(al_full_out), .al_level_out(al_level_out),
        .start_in(start_in), .xfer_len_in(xfer_len_in),
        .abort_in(abort_in), .err_clr_in(err_clr_in),
        .busy_out(busy_out), .done_out(done_out), .err_out(err_out),
        .tl_data_out(tl_data_out), .tl_data_val_out(tl_data_val_out),
        .tl_data_last_out(tl_data_last_out), .tl_data_strobe_in(tl_data_strobe_in)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic wr, logic [31:0] d, logic st, logic [10:0] len,
                                logic sb, logic ab, logic clr, logic [10:0] lvl,
                                logic val, logic last, logic busy, logic done,
                                logic [1:0] err, logic [31:0] q);
        vec_t v;
        v.wr = wr; v.d = d; v.st = st; v.len = len; v.sb = sb; v.ab = ab; v.clr = clr;
        v.lvl = lvl; v.val = val; v.last = last; v.busy = busy; v.done = done;
        v.err = err; v.q = q;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h want %h", nm, act, exp);
        else passed++;
    endtask

    task automatic idle_inputs();
        al_data_val_in = 0; al_data_in = 0; start_in = 0; xfer_len_in = 0;
        abort_in = 0; err_clr_in = 0; tl_data_strobe_in = 0;
    endtask

    task automatic wr(input logic [31:0] d);
        al_data_val_in = 1; al_data_in = d;
        @(posedge clk); #1;
        al_data_val_in = 0;
    endtask

    task automatic send(input int n, input logic [31:0] base);
        int  k = 0;
        bit  seen = 0;
        start_in = 1; xfer_len_in = 11'(n); tl_data_strobe_in = 1;
        @(posedge clk); #1;
        start_in = 0;
        for (int c = 0; c < n + 10 && !seen; c++) begin
            if (tl_data_val_out) begin
                chk("send_data", 64'(tl_data_out), 64'(base + 32'(k)));
                chk("send_last", 64'(tl_data_last_out), 64'(k == n - 1));
                k++;
            end
            @(posedge clk); #1;
            if (done_out) seen = 1;
        end
        chk("send_count", 64'(k), 64'(n));
        chk("send_done", 64'(seen), 64'd1);
        chk("send_level", 64'(al_level_out), 64'd0);
        tl_data_strobe_in = 0;
    endtask

    function automatic logic [63:0] outs_all();
        return {al_level_out, al_full_out, tl_data_val_out, tl_data_last_out,
                busy_out, done_out, err_out, tl_data_out};
    endfunction

    initial begin
        rst = 0;
        idle_inputs();
        #2 chk("reset_outputs", outs_all(), 64'd0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1;

        tv.push_back(mk(1,'h1000,0,0,0,0,0, 1,0,0,0,0,0,0));
        tv.push_back(mk(1,'h1001,0,0,0,0,0, 2,0,0,0,0,0,0));
        tv.push_back(mk(1,'h1002,0,0,0,0,0, 3,0,0,0,0,0,0));
        tv.push_back(mk(1,'h1003,0,0,0,0,0, 4,0,0,0,0,0,0));
        tv.push_back(mk(0,0,1,4,1,0,0,      4,0,0,1,0,0,0));
        tv.push_back(mk(0,0,0,0,1,0,0,      4,1,0,1,0,0,'h1000));
        tv.push_back(mk(0,0,0,0,1,0,0,      3,1,0,1,0,0,'h1001));
        tv.push_back(mk(0,0,0,0,1,0,0,      2,1,0,1,0,0,'h1002));
        tv.push_back(mk(0,0,0,0,1,0,0,      1,1,1,1,0,0,'h1003));
        tv.push_back(mk(0,0,0,0,1,0,0,      0,0,0,0,1,0,0));
        tv.push_back(mk(0,0,0,0,0,0,0,      0,0,0,0,0,0,0));
        tv.push_back(mk(1,'h2000,0,0,0,0,0, 1,0,0,0,0,0,0));
        tv.push_back(mk(1,'h2001,0,0,0,0,0, 2,0,0,0,0,0,0));
        tv.push_back(mk(0,0,1,3,0,0,0,      2,0,0,0,0,2,0));
        tv.push_back(mk(0,0,0,0,0,0,1,      2,0,0,0,0,0,0));
        tv.push_back(mk(0,0,1,0,0,0,0,      2,0,0,0,0,2,0));
        tv.push_back(mk(0,0,1,0,0,0,1,      2,0,0,0,0,2,0));
        tv.push_back(mk(0,0,0,0,0,0,1,      2,0,0,0,0,0,0));
        tv.push_back(mk(1,'h2002,1,3,0,0,0, 3,0,0,0,0,2,0));
        tv.push_back(mk(0,0,1,3,0,0,1,      3,0,0,1,0,0,0));
        tv.push_back(mk(0,0,0,0,0,0,0,      3,1,0,1,0,0,'h2000));
        tv.push_back(mk(1,'h3000,0,0,1,0,0, 3,1,0,1,0,0,'h2001));
        tv.push_back(mk(0,0,0,0,0,0,0,      3,1,0,1,0,0,'h2001));
        tv.push_back(mk(0,0,0,0,1,0,0,      2,1,1,1,0,0,'h2002));
        tv.push_back(mk(0,0,0,0,0,0,0,      2,1,1,1,0,0,'h2002));
        tv.push_back(mk(0,0,1,1,1,0,0,      1,0,0,0,1,0,0));
        tv.push_back(mk(0,0,0,0,0,0,0,      1,0,0,0,0,0,0));
        for (int i = 1; i < 8; i++)
            tv.push_back(mk(1,'h3000 + 32'(i),0,0,0,0,0, 11'(1 + i),0,0,0,0,0,0));
        tv.push_back(mk(0,0,1,8,1,0,0,      8,0,0,1,0,0,0));
        tv.push_back(mk(0,0,0,0,1,0,0,      8,1,0,1,0,0,'h3000));
        tv.push_back(mk(0,0,0,0,1,0,0,      7,1,0,1,0,0,'h3001));
        tv.push_back(mk(0,0,0,0,1,0,0,      6,1,0,1,0,0,'h3002));
        tv.push_back(mk(1,'hdead,0,0,1,1,0, 0,0,0,0,0,0,0));
        tv.push_back(mk(0,0,0,0,0,0,0,      0,0,0,0,0,0,0));
        tv.push_back(mk(1,'h4000,0,0,0,0,0, 1,0,0,0,0,0,0));
        tv.push_back(mk(0,0,1,1,0,0,0,      1,0,0,1,0,0,0));
        tv.push_back(mk(0,0,0,0,0,0,0,      1,1,1,1,0,0,'h4000));
        tv.push_back(mk(0,0,0,0,1,0,0,      0,0,0,0,1,0,0));
        tv.push_back(mk(0,0,0,0,0,0,0,      0,0,0,0,0,0,0));

        foreach (tv[i]) begin
            al_data_val_in = tv[i].wr; al_data_in = tv[i].d; start_in = tv[i].st;
            xfer_len_in = tv[i].len; tl_data_strobe_in = tv[i].sb;
            abort_in = tv[i].ab; err_clr_in = tv[i].clr;
            @(posedge clk); #1;
            chk($sformatf("row%0d", i),
                {al_level_out, al_full_out, tl_data_val_out, tl_data_last_out, busy_out,
                 done_out, err_out, tl_data_val_out ? tl_data_out : 32'd0},
                {tv[i].lvl, tv[i].lvl == 11'd1024, tv[i].val, tv[i].last, tv[i].busy,
                 tv[i].done, tv[i].err, tv[i].val ? tv[i].q : 32'd0});
        end
        idle_inputs();

        for (int i = 0; i < 1024; i++) wr(32'(i));
        chk("fill_level", 64'(al_level_out), 64'd1024);
        chk("fill_full", 64'(al_full_out), 64'd1);
        wr(32'hbad);
        chk("ovf_err", 64'(err_out), 64'd1);
        chk("ovf_level", 64'(al_level_out), 64'd1024);
        err_clr_in = 1;
        @(posedge clk); #1;
        err_clr_in = 0;
        chk("err_clr", 64'(err_out), 64'd0);
        abort_in = 1;
        @(posedge clk); #1;
        abort_in = 0;
        chk("abort_flush", 64'({al_level_out, al_full_out}), 64'd0);

        for (int i = 0; i < 1000; i++) wr(32'h5000 + 32'(i));
        send(1000, 32'h5000);
        for (int i = 0; i < 50; i++) wr(32'h6000 + 32'(i));
        send(50, 32'h6000);
        chk("wrap_err", 64'(err_out), 64'd0);

        for (int i = 0; i < 4; i++) wr(32'h7000 + 32'(i));
        start_in = 1; xfer_len_in = 4;
        @(posedge clk); #1;
        start_in = 0;
        @(posedge clk); #1;
        chk("pre_rst_val", 64'({tl_data_val_out, tl_data_out}), {31'd0, 1'b1, 32'h7000});
        #2 rst = 0;
        #1 chk("async_rst", outs_all(), 64'd0);
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        chk("post_rst", outs_all(), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
